// File: rtl/qrisc32_pkg.sv
// -----------------------------------------------------------------------------
// qrisc32_pkg
// Shared types and constants for the Qrisc32 memory arbiter:
//   owner_t     - which master currently holds the memory port
//   arb_state_t - arbiter FSM states
//   ARB_RUN_W   - width of the consecutive-data-grant run counter
// -----------------------------------------------------------------------------
package qrisc32_pkg;

    localparam int ARB_RUN_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_OWN = 2'd1,
        ST_D_OWN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/qrisc32_arb_stats.sv
// -----------------------------------------------------------------------------
// qrisc32_arb_stats
// Grant and starvation counters for the Qrisc32 memory arbiter. All counters
// are 16 bits and wrap.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   i_done, d_done    - completion strobe of the instruction / data master
//   i_rd              - instruction read request
//   owner             - current port owner
//   stat_i_grants     - instruction completions
//   stat_d_grants     - data completions
//   stat_i_starved    - cycles the fetch master waited while data owned the port
// -----------------------------------------------------------------------------
module qrisc32_arb_stats
    import qrisc32_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_done,
    input  logic        d_done,
    input  logic        i_rd,
    input  owner_t      owner,
    output logic [15:0] stat_i_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_i_starved
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_i_grants  <= '0;
            stat_d_grants  <= '0;
            stat_i_starved <= '0;
        end else begin
            if (i_done) begin
                stat_i_grants <= stat_i_grants + 16'd1;
            end
            if (d_done) begin
                stat_d_grants <= stat_d_grants + 16'd1;
            end
            if (i_rd && (owner == OWN_D)) begin
                stat_i_starved <= stat_i_starved + 16'd1;
            end
        end
    end

endmodule

// File: rtl/qrisc32_mem_arb.sv
// -----------------------------------------------------------------------------
// qrisc32_mem_arb
// Two-master to one-slave Avalon arbiter: the IF-stage fetch master and the
// MEM-stage data master share one memory port. Data wins by default; a run
// counter bounds consecutive data grants while a fetch is pending so the
// fetch master always makes progress. The granted master keeps the port until
// its transfer completes (or it withdraws its request).
//
// Optional feature: define QRISC32_ARB_STATS_EN to build the grant/starvation
// counters; otherwise the stat ports are tied to zero.
//
// Ports:
//   clk, reset_n                         - clock, asynchronous active-low reset
//   i_address, i_rd                      - fetch master request
//   i_data_r, i_wait_req                 - fetch master response
//   d_address, d_rd, d_wr, d_data_w      - data master request
//   d_data_r, d_wait_req                 - data master response
//   m_address, m_rd, m_wr, m_data_w      - slave request
//   m_data_r, m_wait_req                 - slave response
//   owner                                - 0 none, 1 instruction, 2 data
//   stat_i_grants, stat_d_grants,
//   stat_i_starved                       - statistics counters
// -----------------------------------------------------------------------------
module qrisc32_mem_arb
    import qrisc32_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] i_address,
    input  logic          i_rd,
    output logic [DW-1:0] i_data_r,
    output logic          i_wait_req,
    input  logic [AW-1:0] d_address,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [DW-1:0] d_data_w,
    output logic [DW-1:0] d_data_r,
    output logic          d_wait_req,
    output logic [AW-1:0] m_address,
    output logic          m_rd,
    output logic          m_wr,
    output logic [DW-1:0] m_data_w,
    input  logic [DW-1:0] m_data_r,
    input  logic          m_wait_req,
    output logic [1:0]    owner,
    output logic [15:0]   stat_i_grants,
    output logic [15:0]   stat_d_grants,
    output logic [15:0]   stat_i_starved
);

    localparam logic [ARB_RUN_W-1:0] MAX_RUN = ARB_RUN_W'(MAX_D_RUN);

    function automatic logic [ARB_RUN_W-1:0] run_sat_inc(input logic [ARB_RUN_W-1:0] v);
        return (v >= MAX_RUN) ? MAX_RUN : v + ARB_RUN_W'(1);
    endfunction

    arb_state_t           state_q;
    owner_t               owner_q;
    logic [ARB_RUN_W-1:0] run_q;
    logic [DW-1:0]        i_data_q;
    logic [DW-1:0]        d_data_q;

    logic d_req;
    logic xfer_done;
    logic i_done;
    logic d_done;
    logic d_rd_done;

    assign d_req = d_rd | d_wr;

    // Slave port routing: in IDLE the port is parked at zero, so an
    // asynchronous reset drops m_rd/m_wr and clears the bus immediately.
    always_comb begin
        m_address = '0;
        m_data_w  = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        unique case (state_q)
            ST_I_OWN: begin
                m_address = i_address;
                m_rd      = i_rd;
            end
            ST_D_OWN: begin
                m_address = d_address;
                m_data_w  = d_data_w;
                m_wr      = d_wr;
                // Simultaneous read and write is treated as a write.
                m_rd      = d_rd & ~d_wr;
            end
            default: ;
        endcase
    end

    // Outside the OWN states m_rd/m_wr are 0, so xfer_done cannot fire in IDLE.
    assign xfer_done = (m_rd | m_wr) & ~m_wait_req;
    assign i_done    = (state_q == ST_I_OWN) & xfer_done;
    assign d_done    = (state_q == ST_D_OWN) & xfer_done;
    assign d_rd_done = d_done & m_rd;

    assign i_wait_req = ~i_done;
    assign d_wait_req = ~d_done;

    // Read data goes straight through on the completing cycle; otherwise each
    // master sees the last word that was delivered to it.
    assign i_data_r = i_done    ? m_data_r : i_data_q;
    assign d_data_r = d_rd_done ? m_data_r : d_data_q;

    assign owner = owner_q;

    // Arbitration FSM; owner is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            run_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!i_rd) begin
                        run_q <= '0;
                    end
                    if (d_req && (run_q < MAX_RUN)) begin
                        state_q <= ST_D_OWN;
                        owner_q <= OWN_D;
                        if (i_rd) begin
                            run_q <= run_sat_inc(run_q);
                        end
                    end else if (i_rd) begin
                        state_q <= ST_I_OWN;
                        owner_q <= OWN_I;
                        run_q   <= '0;
                    end else if (d_req) begin
                        // Run limit reached but no fetch is waiting.
                        state_q <= ST_D_OWN;
                        owner_q <= OWN_D;
                    end
                end
                ST_I_OWN: begin
                    // A dropped request here is an IF flush: release the port.
                    if (!i_rd || i_done) begin
                        state_q <= ST_IDLE;
                        owner_q <= OWN_NONE;
                    end
                end
                ST_D_OWN: begin
                    if (!d_req || d_done) begin
                        state_q <= ST_IDLE;
                        owner_q <= OWN_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Per-master read data holding registers (datapath, not reset).
    always_ff @(posedge clk) begin
        if (i_done) begin
            i_data_q <= m_data_r;
        end
        if (d_rd_done) begin
            d_data_q <= m_data_r;
        end
    end

`ifdef QRISC32_ARB_STATS_EN
    qrisc32_arb_stats u_stats (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_done         (i_done),
        .d_done         (d_done),
        .i_rd           (i_rd),
        .owner          (owner_q),
        .stat_i_grants  (stat_i_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_i_starved (stat_i_starved)
    );
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_i_starved = '0;
`endif

`ifndef SYNTHESIS
    a_no_rd_wr_together : assert property (@(posedge clk) disable iff (!reset_n) !(d_rd && d_wr))
        else $error("qrisc32_mem_arb: d_rd and d_wr asserted together, treated as write");
`endif

endmodule

// File: tb/tb_qrisc32_mem_arb.sv
module tb_qrisc32_mem_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_address;
    logic        i_rd;
    logic [31:0] i_data_r;
    logic        i_wait_req;
    logic [31:0] d_address;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_data_w;
    logic [31:0] d_data_r;
    logic        d_wait_req;
    logic [31:0] m_address;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_data_w;
    logic [31:0] m_data_r;
    logic        m_wait_req;
    logic [1:0]  owner;
    logic [15:0] stat_i_grants;
    logic [15:0] stat_d_grants;
    logic [15:0] stat_i_starved;

    always #5 clk = ~clk;

    // Slave model: read data is a fixed function of the address.
    assign m_data_r = m_address ^ 32'h5A5A_0000;

    qrisc32_mem_arb #(.AW(32), .DW(32), .MAX_D_RUN(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_address      (i_address),
        .i_rd           (i_rd),
        .i_data_r       (i_data_r),
        .i_wait_req     (i_wait_req),
        .d_address      (d_address),
        .d_rd           (d_rd),
        .d_wr           (d_wr),
        .d_data_w       (d_data_w),
        .d_data_r       (d_data_r),
        .d_wait_req     (d_wait_req),
        .m_address      (m_address),
        .m_rd           (m_rd),
        .m_wr           (m_wr),
        .m_data_w       (m_data_w),
        .m_data_r       (m_data_r),
        .m_wait_req     (m_wait_req),
        .owner          (owner),
        .stat_i_grants  (stat_i_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_i_starved (stat_i_starved)
    );

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic [1:0]  exp_owner;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  own;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   comp_cnt = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input bit is_d, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int nwait,
                                 input logic [1:0] own, input logic [31:0] rdata);
        vec_t v;
        v.is_d = is_d; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.nwait = nwait; v.exp_owner = own; v.exp_rdata = rdata;
        return v;
    endfunction

    function automatic exp_t mke(input logic [1:0] own, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.own = own; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        return e;
    endfunction

    // Completion monitor: pops the scoreboard on every completing cycle.
    always @(negedge clk) begin
        if (reset_n && (owner != 2'd0) && (m_rd || m_wr) && !m_wait_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", {30'd0, owner}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("comp_owner", {30'd0, owner}, {30'd0, mon_e.own});
                chk("comp_m_address", m_address, mon_e.addr);
                chk("comp_m_wr", {31'd0, m_wr}, {31'd0, mon_e.wr});
                chk("comp_m_rd", {31'd0, m_rd}, {31'd0, !mon_e.wr});
                if (mon_e.own == 2'd2) begin
                    chk("comp_d_wait_req", {31'd0, d_wait_req}, 32'd0);
                    chk("comp_i_wait_req_other", {31'd0, i_wait_req}, 32'd1);
                    if (mon_e.wr) chk("comp_m_data_w", m_data_w, mon_e.wdata);
                    else          chk("comp_d_data_r", d_data_r, mon_e.rdata);
                end else begin
                    chk("comp_i_wait_req", {31'd0, i_wait_req}, 32'd0);
                    chk("comp_d_wait_req_other", {31'd0, d_wait_req}, 32'd1);
                    chk("comp_i_data_r", i_data_r, mon_e.rdata);
                end
            end
            comp_cnt++;
        end
    end

    task automatic wait_comp(input int target, input int budget, input string name);
        int n;
        n = 0;
        while ((comp_cnt < target) && (n < budget)) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'd0, (comp_cnt >= target)}, 32'd1);
    endtask

    // One isolated transfer from IDLE; called at posedge+1.
    task automatic xfer(input vec_t v);
        int own_seen;
        int start;
        bit got;
        exp_q.push_back(mke(v.exp_owner, v.wr, v.addr, v.wdata, v.exp_rdata));
        start    = comp_cnt;
        own_seen = 0;
        got      = 1'b0;
        if (v.is_d) begin
            d_address = v.addr; d_data_w = v.wdata; d_wr = v.wr; d_rd = !v.wr;
        end else begin
            i_address = v.addr; i_rd = 1'b1;
        end
        m_wait_req = (v.nwait > 0);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("arb_cycle_owner", {30'd0, owner}, 32'd0);
            end else if (owner != 2'd0) begin
                if (own_seen < v.nwait) begin
                    chk("stall_owner", {30'd0, owner}, {30'd0, v.exp_owner});
                    chk("stall_m_address", m_address, v.addr);
                    chk("stall_m_wr", {31'd0, m_wr}, {31'd0, v.wr});
                    chk("stall_i_wait_req", {31'd0, i_wait_req}, 32'd1);
                    chk("stall_d_wait_req", {31'd0, d_wait_req}, 32'd1);
                    if (v.is_d && v.wr) chk("stall_m_data_w", m_data_w, v.wdata);
                end
                own_seen++;
            end
            @(posedge clk); #1;
            if (comp_cnt != start) begin
                got = 1'b1;
                break;
            end
            m_wait_req = (own_seen < v.nwait);
        end
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; m_wait_req = 1'b0;
        if (!got) chk("xfer_timeout", {31'd0, got}, 32'd1);
        else      chk("comp_cycle_index", own_seen, v.nwait + 1);
        @(negedge clk);
        chk("post_idle_owner", {30'd0, owner}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int start;

        tbl[0] = mkv(1'b0, 1'b0, 32'h0000_0010, 32'h0,          0, 2'd1, 32'h5A5A_0010);
        tbl[1] = mkv(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF,  3, 2'd2, 32'h0);
        tbl[2] = mkv(1'b1, 1'b0, 32'h0000_0200, 32'h0,          0, 2'd2, 32'h5A5A_0200);
        tbl[3] = mkv(1'b0, 1'b0, 32'h0000_1234, 32'h0,          2, 2'd1, 32'h5A5A_1234);
        tbl[4] = mkv(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678,  1, 2'd2, 32'h0);
        tbl[5] = mkv(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          0, 2'd2, 32'hA5A5_FFFC);
        tbl[6] = mkv(1'b0, 1'b0, 32'h0000_0000, 32'h0,          0, 2'd1, 32'h5A5A_0000);
        tbl[7] = mkv(1'b1, 1'b0, 32'h0000_0300, 32'h0,          0, 2'd2, 32'h5A5A_0300);

        reset_n = 1'b0;
        i_address = '0; i_rd = 1'b0;
        d_address = '0; d_rd = 1'b0; d_wr = 1'b0; d_data_w = '0;
        m_wait_req = 1'b0;
        #1;
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_m_rd", {31'd0, m_rd}, 32'd0);
        chk("rst_m_wr", {31'd0, m_wr}, 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_data_w", m_data_w, 32'd0);
        chk("rst_i_wait_req", {31'd0, i_wait_req}, 32'd1);
        chk("rst_d_wait_req", {31'd0, d_wait_req}, 32'd1);
        chk("rst_stat_i_grants", {16'd0, stat_i_grants}, 32'd0);
        chk("rst_stat_d_grants", {16'd0, stat_d_grants}, 32'd0);
        chk("rst_stat_i_starved", {16'd0, stat_i_starved}, 32'd0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        // Isolated transfers from the vector table.
        for (int k = 0; k < 8; k++) begin
            xfer(tbl[k]);
        end

        @(negedge clk);
        chk("hold_i_data_r", i_data_r, 32'h5A5A_0000);
        chk("hold_d_data_r", d_data_r, 32'h5A5A_0300);
`ifdef QRISC32_ARB_STATS_EN
        chk("stat_i_grants_3", {16'd0, stat_i_grants}, 32'd3);
        chk("stat_d_grants_5", {16'd0, stat_d_grants}, 32'd5);
        chk("stat_i_starved_0", {16'd0, stat_i_starved}, 32'd0);
`else
        chk("stat_i_grants_off", {16'd0, stat_i_grants}, 32'd0);
        chk("stat_d_grants_off", {16'd0, stat_d_grants}, 32'd0);
        chk("stat_i_starved_off", {16'd0, stat_i_starved}, 32'd0);
`endif
        @(posedge clk); #1;

        // Data priority: both request together, data first.
        exp_q.push_back(mke(2'd2, 1'b0, 32'h200, 32'h0, 32'h5A5A_0200));
        exp_q.push_back(mke(2'd1, 1'b0, 32'h100, 32'h0, 32'h5A5A_0100));
        start = comp_cnt;
        i_address = 32'h100; i_rd = 1'b1;
        d_address = 32'h200; d_rd = 1'b1;
        @(negedge clk);
        chk("prio_arb_owner", {30'd0, owner}, 32'd0);
        @(negedge clk);
        chk("prio_d_first", {30'd0, owner}, 32'd2);
        chk("prio_m_address", m_address, 32'h200);
        chk("prio_i_wait_req", {31'd0, i_wait_req}, 32'd1);
        wait_comp(start + 1, 10, "prio_d_done");
        d_rd = 1'b0;
        wait_comp(start + 2, 10, "prio_i_done");
        i_rd = 1'b0;
        @(negedge clk);
        chk("prio_post_idle", {30'd0, owner}, 32'd0);
`ifdef QRISC32_ARB_STATS_EN
        chk("stat_i_starved_1", {16'd0, stat_i_starved}, 32'd1);
`endif
        @(posedge clk); #1;

        // Starvation limit: D,D,D,D,I,D,D,D,D,I with both held.
        for (int k = 0; k < 10; k++) begin
            if ((k == 4) || (k == 9)) exp_q.push_back(mke(2'd1, 1'b0, 32'h100, 32'h0, 32'h5A5A_0100));
            else                      exp_q.push_back(mke(2'd2, 1'b0, 32'h200, 32'h0, 32'h5A5A_0200));
        end
        start = comp_cnt;
        i_address = 32'h100; i_rd = 1'b1;
        d_address = 32'h200; d_rd = 1'b1;
        wait_comp(start + 10, 60, "starve_seq_done");
        i_rd = 1'b0; d_rd = 1'b0;
        @(negedge clk);
        chk("starve_post_idle", {30'd0, owner}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stalled data write.
        d_address = 32'h40; d_data_w = 32'hCAFE_F00D; d_wr = 1'b1;
        m_wait_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_owner_d", {30'd0, owner}, 32'd2);
        chk("mid_m_wr", {31'd0, m_wr}, 32'd1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_m_wr", {31'd0, m_wr}, 32'd0);
        chk("mid_rst_m_rd", {31'd0, m_rd}, 32'd0);
        chk("mid_rst_owner", {30'd0, owner}, 32'd0);
        chk("mid_rst_d_wait_req", {31'd0, d_wait_req}, 32'd1);
        chk("mid_rst_i_wait_req", {31'd0, i_wait_req}, 32'd1);
        chk("mid_rst_m_address", m_address, 32'd0);
        chk("mid_rst_stat_d", {16'd0, stat_d_grants}, 32'd0);
        d_wr = 1'b0; m_wait_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        xfer(mkv(1'b0, 1'b0, 32'h44, 32'h0, 0, 2'd1, 32'h5A5A_0044));

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
